access_event_monitor: RTL and testbench
=======================================

Name: access_event_monitor

Overview:
- Downstream consumer of the access_system output stream. Observes one (user_id, resource_id) access event per cycle.
- Tags each event with a free-running timestamp, a first-seen user→resource edge flag and a per-user burst flag.
- Buffers tagged records in a small FIFO for the graph-export/logging stage, which applies backpressure via valid/ready.

Parameters:
ID_W, 4, width of user_id and resource_id
TS_W, 16, timestamp width; wraps modulo 2^TS_W
WINDOW, 16, rate-window length in cycles (>=2)
BURST_TH, 4, per-user event count within one window at which burst is flagged (1..15)
FIFO_DEPTH, 8, record FIFO depth (power of 2)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
in_valid  in  1  access event present this cycle (no backpressure upstream)
in_user_id  in  ID_W  user of event
in_resource_id  in  ID_W  resource of event
out_valid  out  1  record available at FIFO head
out_ready  in  1  consumer accepts head record
out_timestamp  out  TS_W  timestamp of record
out_user_id  out  ID_W  user of record
out_resource_id  out  ID_W  resource of record
out_new_edge  out  1  first occurrence of this user→resource pair since reset
out_burst  out  1  user's in-window count reached BURST_TH
fifo_level  out  log2(FIFO_DEPTH)+1  records held
drop_count  out  8  events lost to full FIFO, saturating at 255

Behaviour:
- Clocking and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: out_valid=0, fifo_level=0, drop_count=0. Record outputs are 0.
- Reset also clears the timestamp, window counter, all per-user counters and the full edge bitmap.
- Reset mid-operation discards all buffered records.
- Timestamp: ts=0 during reset. It increments by 1 on every non-reset edge and wraps 2^TS_W-1→0.
  - An event accepted at an edge carries the ts value present before that edge.
  - First event sampled after reset deassertion: ts=0.
- Event accept: every edge with in_valid=1 and rst=0. Each input is sampled exactly once; there is no input handshake.
- Edge bitmap: 2^ID_W x 2^ID_W bits.
  - new_edge = NOT bitmap[user][res] before the edge; the bit is set at the accepting edge.
  - Back-to-back identical events: the first gets new_edge=1, the second gets 0.
- Rate window:
  - A window counter counts 0..WINDOW-1 every cycle and wraps.
  - Per-user 4-bit counters saturate at 15. Tag computation: cnt_next = sat(cnt[user]+1); burst = (cnt_next >= BURST_TH).
  - On the edge where the window counter = WINDOW-1, an event in that cycle is tagged using the old window's count. All per-user counters then become 0; the clear overrides the increment.
- Statistics are updated for every accepted event, including events dropped by the FIFO.
- FIFO: first-word-fall-through.
  - An event accepted at edge N is visible on out_* with out_valid=1 in the cycle after edge N, provided the FIFO was empty. Latency is 1.
  - Pop occurs on an edge with out_valid && out_ready.
  - Push when full: accepted only if a pop occurs on the same edge; otherwise the record is dropped and drop_count increments (saturating).
  - Simultaneous push and pop leaves fifo_level unchanged.
  - Records leave strictly in arrival order.
  - out_* are held stable while out_valid=1 and out_ready=0.
- Empty: out_valid=0. With out_ready=1 and no events, fifo_level stays 0.

Test Plan:
1. Hold rst=1 for 3 cycles, then release with in_valid=0 -> out_valid=0, fifo_level=0, drop_count=0. First event one cycle after release carries out_timestamp=0.
2. out_ready=1, event (3,5) then (3,5) on consecutive cycles -> two records in order. First: new_edge=1, burst=0, ts=t. Second: new_edge=0, ts=t+1.
3. BURST_TH=4, WINDOW=16: user 2 sends 4 events in one window -> 4th record has burst=1, first three have burst=0. First user-2 event after the window wrap -> burst=0.
4. out_ready=0, 10 consecutive events -> fifo_level=8, drop_count=2. Then out_ready=1 drains exactly the first 8 events in order, ending with fifo_level=0.
5. FIFO full, same edge has out_ready=1 and in_valid=1 -> no drop, fifo_level stays 8, new record at tail.
6. After traffic, assert rst for 1 cycle mid-stream -> FIFO emptied, drop_count=0. Re-sent (3,5) -> new_edge=1, timestamp restarts from 0.

Source files
------------

// File: rtl/access_event_monitor.sv
// Access event monitor: tags each (user, resource) event with a timestamp, a first-seen
// edge flag and a per-user burst flag, then queues the record in a first-word-fall-through FIFO.
module access_event_monitor #(
  parameter int ID_W       = 4,
  parameter int TS_W       = 16,
  parameter int WINDOW     = 16,
  parameter int BURST_TH   = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [ID_W-1:0]               in_user_id,
  input  logic [ID_W-1:0]               in_resource_id,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [TS_W-1:0]               out_timestamp,
  output logic [ID_W-1:0]               out_user_id,
  output logic [ID_W-1:0]               out_resource_id,
  output logic                          out_new_edge,
  output logic                          out_burst,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [7:0]                    drop_count
);

  localparam int NUM_ID   = 2 ** ID_W;
  localparam int PAIR_W   = 2 * ID_W;
  localparam int NUM_PAIR = 2 ** PAIR_W;
  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int LW       = AW + 1;
  localparam int WIN_W    = (WINDOW > 2) ? $clog2(WINDOW) : 1;
  localparam int REC_W    = TS_W + 2 * ID_W + 2;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  logic [TS_W-1:0]   ts_r;
  logic [WIN_W-1:0]  win_r;
  logic [3:0]        user_cnt_r [NUM_ID];
  logic [NUM_PAIR-1:0] edge_map_r;
  logic [REC_W-1:0]  fifo_mem_r [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [LW-1:0]     count_r;
  logic [7:0]        drop_r;

  logic              win_end_s;
  logic [PAIR_W-1:0] pair_s;
  logic [3:0]        cnt_next_s;
  logic              new_edge_s;
  logic              burst_s;
  logic [REC_W-1:0]  rec_s;
  logic              full_s;
  logic              pop_s;
  logic              push_ok_s;
  logic              drop_s;
  logic [REC_W-1:0]  head_s;

  // Event tagging and FIFO push/pop decisions.
  always_comb begin
    win_end_s  = (win_r == WIN_W'(WINDOW - 1));
    pair_s     = {in_user_id, in_resource_id};
    cnt_next_s = sat_inc4(user_cnt_r[in_user_id]);
    new_edge_s = ~edge_map_r[pair_s];
    burst_s    = (cnt_next_s >= 4'(BURST_TH));
    rec_s      = {ts_r, in_user_id, in_resource_id, new_edge_s, burst_s};
    full_s     = (count_r == LW'(FIFO_DEPTH));
    pop_s      = (count_r != {LW{1'b0}}) && out_ready;
    push_ok_s  = in_valid && (!full_s || pop_s);
    drop_s     = in_valid && full_s && !pop_s;
  end

  // Free-running timestamp; an event carries the value held before its edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      ts_r <= {TS_W{1'b0}};
    end else begin
      ts_r <= ts_r + TS_W'(1);
    end
  end

  // Rate-window position counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_r <= {WIN_W{1'b0}};
    end else if (win_end_s) begin
      win_r <= {WIN_W{1'b0}};
    end else begin
      win_r <= win_r + WIN_W'(1);
    end
  end

  // Per-user event counters; the window-end clear wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst || win_end_s) begin
      for (int i = 0; i < NUM_ID; i++) begin
        user_cnt_r[i] <= 4'd0;
      end
    end else if (in_valid) begin
      user_cnt_r[in_user_id] <= cnt_next_s;
    end
  end

  // First-seen user->resource bitmap.
  always_ff @(posedge clk) begin
    if (rst) begin
      edge_map_r <= {NUM_PAIR{1'b0}};
    end else if (in_valid) begin
      edge_map_r[pair_s] <= 1'b1;
    end
  end

  // Record storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem_r[i] <= {REC_W{1'b0}};
      end
    end else if (push_ok_s) begin
      fifo_mem_r[wr_ptr_r] <= rec_s;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {LW{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_ok_s, pop_s})
        2'b10:   count_r <= count_r + LW'(1);
        2'b01:   count_r <= count_r - LW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Saturating count of events lost to a full FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_r <= 8'd0;
    end else if (drop_s && (drop_r != 8'hFF)) begin
      drop_r <= drop_r + 8'd1;
    end
  end

  // Head-of-FIFO presentation; record fields read as zero while empty.
  always_comb begin
    head_s          = fifo_mem_r[rd_ptr_r];
    out_valid       = (count_r != {LW{1'b0}});
    out_timestamp   = {TS_W{1'b0}};
    out_user_id     = {ID_W{1'b0}};
    out_resource_id = {ID_W{1'b0}};
    out_new_edge    = 1'b0;
    out_burst       = 1'b0;
    if (out_valid) begin
      {out_timestamp, out_user_id, out_resource_id, out_new_edge, out_burst} = head_s;
    end else begin
      out_burst = 1'b0;
    end
    fifo_level = count_r;
    drop_count = drop_r;
  end

endmodule

// File: tb/tb_access_event_monitor.sv
// Scoreboard bench for access_event_monitor: stimulus queues expected records,
// a negedge monitor pops and compares each record the consumer accepts.
module tb_access_event_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [3:0]  in_user_id;
  logic [3:0]  in_resource_id;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_timestamp;
  logic [3:0]  out_user_id;
  logic [3:0]  out_resource_id;
  logic        out_new_edge;
  logic        out_burst;
  logic [3:0]  fifo_level;
  logic [7:0]  drop_count;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  logic [25:0] exp_q [$];

  access_event_monitor dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_user_id(in_user_id),
    .in_resource_id(in_resource_id), .out_valid(out_valid), .out_ready(out_ready),
    .out_timestamp(out_timestamp), .out_user_id(out_user_id),
    .out_resource_id(out_resource_id), .out_new_edge(out_new_edge),
    .out_burst(out_burst), .fifo_level(fifo_level), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  // Cycles since reset release equal the timestamp an event driven now will carry.
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    logic [25:0] got;
    logic [25:0] exp;
    if (!rst && out_valid && out_ready) begin
      checks++;
      got = {out_timestamp, out_user_id, out_resource_id, out_new_edge, out_burst};
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL record: unexpected record ts=%0d u=%0d r=%0d new=%0d burst=%0d, none required",
                 out_timestamp, out_user_id, out_resource_id, out_new_edge, out_burst);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          fails++;
          $display("FAIL record: got ts=%0d u=%0d r=%0d new=%0d burst=%0d, required ts=%0d u=%0d r=%0d new=%0d burst=%0d",
                   got[25:10], got[9:6], got[5:2], got[1], got[0],
                   exp[25:10], exp[9:6], exp[5:2], exp[1], exp[0]);
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] u, input logic [3:0] r,
                      input logic exp_new, input logic exp_burst, input bit keep);
    in_valid       = 1'b1;
    in_user_id     = u;
    in_resource_id = r;
    if (keep) exp_q.push_back({16'(cyc), u, r, exp_new, exp_burst});
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_window(input int pos);
    for (int n = 0; n < 40 && (cyc % 16) != pos; n++) tick();
    check("window_align", cyc % 16, pos);
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 40 && fifo_level != 4'd0; n++) tick();
    check("drain_level", int'(fifo_level), 0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_out_valid"}, int'(out_valid), 0);
    check({tag, "_fifo_level"}, int'(fifo_level), 0);
    check({tag, "_drop_count"}, int'(drop_count), 0);
    check({tag, "_out_fields"},
          int'({out_timestamp, out_user_id, out_resource_id, out_new_edge, out_burst}), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_user_id = 4'd0; in_resource_id = 4'd0; out_ready = 1'b1;
    // Reset held for three edges; reset state checked before release.
    repeat (3) tick();
    check_reset_state("reset");
    rst = 1'b0;
    send(4'd1, 4'd1, 1'b1, 1'b0, 1'b1);            // first event after release: ts 0
    tick();

    // Back-to-back identical events.
    send(4'd3, 4'd5, 1'b1, 1'b0, 1'b1);
    send(4'd3, 4'd5, 1'b0, 1'b0, 1'b1);
    tick();

    // Burst within one window, old-window tagging at window end, clear after wrap.
    wait_window(0);
    send(4'd2, 4'd0, 1'b1, 1'b0, 1'b1);
    send(4'd2, 4'd1, 1'b1, 1'b0, 1'b1);
    send(4'd2, 4'd2, 1'b1, 1'b0, 1'b1);
    send(4'd2, 4'd2, 1'b0, 1'b1, 1'b1);
    wait_window(15);
    send(4'd2, 4'd0, 1'b0, 1'b1, 1'b1);
    send(4'd2, 4'd7, 1'b1, 1'b0, 1'b1);
    wait_drain();

    // Ten events into a stalled consumer: eight kept, two dropped.
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) send(4'(4 + i), 4'd0, 1'b1, 1'b0, i < 8);
    check("full_level", int'(fifo_level), 8);
    check("full_drops", int'(drop_count), 2);
    check("full_valid", int'(out_valid), 1);

    // Push into a full FIFO on the same edge as a pop.
    out_ready = 1'b1;
    send(4'd14, 4'd0, 1'b1, 1'b0, 1'b1);
    check("push_pop_level", int'(fifo_level), 8);
    check("push_pop_drops", int'(drop_count), 2);
    wait_drain();
    check("drain_queue", exp_q.size(), 0);

    // Mid-stream reset discards buffered records and statistics.
    out_ready = 1'b0;
    send(4'd1, 4'd2, 1'b1, 1'b0, 1'b0);
    send(4'd1, 4'd3, 1'b1, 1'b0, 1'b0);
    check("pre_reset_level", int'(fifo_level), 2);
    rst = 1'b1;
    exp_q.delete();
    tick();
    check_reset_state("midreset");
    rst = 1'b0;
    out_ready = 1'b1;
    send(4'd3, 4'd5, 1'b1, 1'b0, 1'b1);
    wait_drain();
    check("final_queue", exp_q.size(), 0);
    check("final_drops", int'(drop_count), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
